// File: rtl/draw_image_rom.sv
// Streams an IMG_W x IMG_H image from a synchronous ROM to a VGA plot port at
// a latched screen origin, one pixel per cycle, with clipping and optional colour keying.
module draw_image_rom #(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int SCR_W      = 160,
    parameter int SCR_H      = 120,
    parameter int COLOUR_W   = 9,
    parameter int ADDR_W     = 15,
    parameter int KEY_EN     = 0,
    parameter int KEY_COLOUR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          x_org,
    input  logic [6:0]          y_org,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int N     = IMG_W * IMG_H;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [COL_W-1:0]    LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [9:0]          SCR_W_L   = 10'(SCR_W);
    localparam logic [9:0]          SCR_H_L   = 10'(SCR_H);
    localparam logic [COLOUR_W-1:0] KEY_C     = COLOUR_W'(KEY_COLOUR);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [7:0]         xo_q, xo_d;
    logic [6:0]         yo_q, yo_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic               vld_q, vld_d;
    logic               inb_q, inb_d;
    logic               done_q, done_d;
    logic [8:0]         xs;
    logic [7:0]         ys;

    // Origin sums are one bit wider than the screen coordinates so that
    // off-screen pixels clip instead of wrapping back onto the screen.
    assign xs = {1'b0, xo_q} + 9'(col_q);
    assign ys = {1'b0, yo_q} + 8'(row_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        x_d     = x_q;
        y_d     = y_q;
        inb_d   = inb_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    xo_d    = x_org;
                    yo_d    = y_org;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            DRAW: begin
                // Pixel coordinates are registered alongside the ROM read so
                // they line up with rom_q on the following cycle.
                vld_d = 1'b1;
                x_d   = xs[7:0];
                y_d   = ys[6:0];
                inb_d = ({1'b0, xs} < SCR_W_L) && ({2'b0, ys} < SCR_H_L);
                if (addr_q == LAST_ADDR) begin
                    state_d = FLUSH;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                addr_d  = '0;
                col_d   = '0;
                row_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
            inb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
            inb_q   <= inb_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = rom_q;
    assign plot     = vld_q && inb_q && !((KEY_EN != 0) && (rom_q == KEY_C));
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_draw_image_rom.sv
// Bench for draw_image_rom: three configurations (4x3 keyed, 4x3 clipped at 12, 160x120 default)
// checked cycle by cycle against a per-pixel raster model.
module tb_draw_image_rom;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x_org = '0;
    logic [6:0] y_org = '0;
    int         sel = 0;

    logic [14:0] ra [3];
    logic [8:0]  rq [3];
    logic [7:0]  xo [3];
    logic [6:0]  yo [3];
    logic [8:0]  co [3];
    logic        pl [3];
    logic        bz [3];
    logic        dn [3];

    logic [8:0] rom [0:19199];

    int img_w [3] = '{4, 4, 160};
    int img_h [3] = '{3, 3, 120};
    int scr_w [3] = '{160, 12, 160};
    int scr_h [3] = '{120, 120, 120};
    int key   [3] = '{1, 0, 0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    draw_image_rom #(.IMG_W(4), .IMG_H(3), .KEY_EN(1), .KEY_COLOUR(0)) u0 (
        .clk(clk), .reset(reset), .start(start && sel == 0), .x_org(x_org), .y_org(y_org),
        .rom_addr(ra[0]), .rom_q(rq[0]), .x(xo[0]), .y(yo[0]), .colour(co[0]),
        .plot(pl[0]), .busy(bz[0]), .done(dn[0]));

    draw_image_rom #(.IMG_W(4), .IMG_H(3), .SCR_W(12)) u1 (
        .clk(clk), .reset(reset), .start(start && sel == 1), .x_org(x_org), .y_org(y_org),
        .rom_addr(ra[1]), .rom_q(rq[1]), .x(xo[1]), .y(yo[1]), .colour(co[1]),
        .plot(pl[1]), .busy(bz[1]), .done(dn[1]));

    draw_image_rom u2 (
        .clk(clk), .reset(reset), .start(start && sel == 2), .x_org(x_org), .y_org(y_org),
        .rom_addr(ra[2]), .rom_q(rq[2]), .x(xo[2]), .y(yo[2]), .colour(co[2]),
        .plot(pl[2]), .busy(bz[2]), .done(dn[2]));

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rq[i] <= rom[ra[i]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete draw: start is accepted at the first edge (E0); then every cycle up
    // to the done cycle is compared with the raster model. Start and origin are
    // jittered while busy unless start is being held for a back-to-back draw.
    task automatic draw_check(input int s, input int x0, input int y0, input bit hold,
                              input int exp_plots);
        int  w, n, np, k, xs, ys;
        bit  ep;
        w  = img_w[s];
        n  = w * img_h[s];
        np = 0;
        sel   = s;
        x_org = 8'(x0);
        y_org = 7'(y0);
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_e0", 32'(bz[s]), 1);
        chk("addr_e0", 32'(ra[s]), 0);
        chk("plot_e0", 32'(pl[s]), 0);
        chk("done_e0", 32'(dn[s]), 0);
        start = hold ? 1'b1 : 1'($urandom);
        x_org = 8'($urandom);
        y_org = 7'($urandom);
        for (int t = 1; t <= n + 1; t++) begin
            @(posedge clk); #1;
            chk("busy", 32'(bz[s]), (t <= n) ? 1 : 0);
            chk("done", 32'(dn[s]), (t == n + 1) ? 1 : 0);
            if (t < n) chk("rom_addr", 32'(ra[s]), t);
            ep = 1'b0;
            k  = t - 1;
            xs = x0 + (k % w);
            ys = y0 + (k / w);
            if (t <= n)
                ep = (xs < scr_w[s]) && (ys < scr_h[s]) && !(key[s] != 0 && rom[k] == 9'd0);
            chk("plot", 32'(pl[s]), ep ? 1 : 0);
            if (ep) begin
                np++;
                chk("x", 32'(xo[s]), xs);
                chk("y", 32'(yo[s]), ys);
                chk("colour", 32'(co[s]), 32'(rom[k]));
            end
            if (t <= n) begin
                start = hold ? 1'b1 : 1'($urandom);
                x_org = 8'($urandom);
                y_org = 7'($urandom);
            end else begin
                start = hold;
            end
        end
        if (exp_plots >= 0) chk("plot_count", np, exp_plots);
    endtask

    typedef struct {
        int s;
        int x0;
        int y0;
        bit hold;
        bit key5;
        int exp_plots;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int zi;
        logic [8:0] saved;
        tbl[0] = '{0, 10, 5, 1'b0, 1'b0, 12};
        tbl[1] = '{1, 10, 5, 1'b0, 1'b0, 6};
        tbl[2] = '{0, 10, 5, 1'b0, 1'b1, 11};
        tbl[3] = '{0, 10, 5, 1'b1, 1'b0, 12};
        tbl[4] = '{0, 20, 30, 1'b0, 1'b0, 12};
        tbl[5] = '{0, 158, 118, 1'b0, 1'b0, 4};
        tbl[6] = '{0, 255, 127, 1'b0, 1'b0, 0};
        tbl[7] = '{1, 11, 0, 1'b0, 1'b0, 3};
        tbl[8] = '{2, 0, 0, 1'b0, 1'b0, 19200};

        for (int i = 0; i < 19200; i++) rom[i] = 9'(1 + ($urandom % 511));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bz[0]), 0);
        chk("rst_done", 32'(dn[0]), 0);
        chk("rst_plot", 32'(pl[0]), 0);
        chk("rst_addr", 32'(ra[0]), 0);
        chk("rst_x", 32'(xo[0]), 0);
        chk("rst_y", 32'(yo[0]), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            saved = rom[5];
            if (tbl[i].key5) rom[5] = 9'd0;
            draw_check(tbl[i].s, tbl[i].x0, tbl[i].y0, tbl[i].hold, tbl[i].exp_plots);
            rom[5] = saved;
        end

        // Reset while pixel 6 is on the output: everything clears and no done follows.
        sel = 0; x_org = 8'd10; y_org = 7'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_plot6", 32'(pl[0]), 1);
        chk("mid_x6", 32'(xo[0]), 12);
        chk("mid_y6", 32'(yo[0]), 6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_busy", 32'(bz[0]), 0);
        chk("mid_plot", 32'(pl[0]), 0);
        chk("mid_addr", 32'(ra[0]), 0);
        chk("mid_done", 32'(dn[0]), 0);
        chk("mid_x", 32'(xo[0]), 0);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(dn[0]), 0);
            chk("post_rst_busy", 32'(bz[0]), 0);
        end
        draw_check(0, 10, 5, 1'b0, 12);

        // Reset wins over start at the same edge.
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("rst_prio_busy", 32'(bz[0]), 0);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_prio_idle", 32'(bz[0]), 0);

        // Random origins and keyed holes on the small configurations.
        for (int i = 0; i < 8; i++) begin
            zi = int'($urandom % 12);
            saved = rom[zi];
            if ($urandom % 2 == 0) rom[zi] = 9'd0;
            draw_check(int'($urandom % 2), int'($urandom % 256), int'($urandom % 128), 1'b0, -1);
            rom[zi] = saved;
        end

        draw_check(tbl[8].s, tbl[8].x0, tbl[8].y0, tbl[8].hold, tbl[8].exp_plots);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_image_rom.md
DRAW_IMAGE_ROM -- requirements
Module: draw_image_rom

Interface
REQ-001 SHALL provide parameter IMG_W, default 160, image width in pixels.
REQ-002 SHALL provide parameter IMG_H, default 120, image height in pixels.
REQ-003 SHALL provide parameter SCR_W, default 160, screen width, used for clipping.
REQ-004 SHALL provide parameter SCR_H, default 120, screen height, used for clipping.
REQ-005 SHALL provide parameter COLOUR_W, default 9, pixel colour width.
REQ-006 SHALL provide parameter ADDR_W, default 15, ROM address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-007 SHALL provide parameter KEY_EN, default 0; 1 enables transparent-colour suppression.
REQ-008 SHALL provide parameter KEY_COLOUR, default 0, transparent colour value.
REQ-009 SHALL provide ports: clk  in  1  single clock, all logic on rising edge.
REQ-010 SHALL provide ports: reset  in  1  synchronous, active-high reset.
REQ-011 SHALL provide ports: start  in  1  draw request, sampled only in IDLE.
REQ-012 SHALL provide ports: x_org  in  8  and  y_org  in  7  top-left screen origin, latched on accepted start.
REQ-013 SHALL provide ports: rom_addr  out  ADDR_W  external synchronous ROM address, 1-cycle read latency.
REQ-014 SHALL provide ports: rom_q  in  COLOUR_W  ROM data.
REQ-015 SHALL provide ports: x  out  8,  y  out  7,  colour  out  COLOUR_W,  plot  out  1  VGA write strobe.
REQ-016 SHALL provide ports: busy  out  1, and done  out  1, a one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, DRAW, FLUSH; reset enters IDLE.
REQ-018 In IDLE, start=1 at edge E0 SHALL latch x_org/y_org, enter DRAW, set busy=1, and drive rom_addr=0.
REQ-019 In DRAW, rom_addr SHALL increment by 1 per cycle, so that after edge Ek rom_addr=k, for k=0..N-1, N=IMG_W*IMG_H.
REQ-020 rom_addr SHALL be produced by incrementing the counter; no multiplier; col wraps IMG_W-1 -> 0 and row increments.
REQ-021 After the edge issuing address N-1, the block SHALL enter FLUSH for exactly one cycle, then return to IDLE.
REQ-022 Pixel k (col c, row r) SHALL be output in the cycle after edge E(k+1): x=x_org+c, y=y_org+r, colour=rom_q.
REQ-023 x/y sums SHALL be computed at 9/8 bits before clipping; no wrap-around is permitted.
REQ-024 plot SHALL be 1 for pixel k only if x_org+c < SCR_W and y_org+r < SCR_H and !(KEY_EN && rom_q==KEY_COLOUR).
REQ-025 plot SHALL be 0 in every cycle not carrying a valid pixel.
REQ-026 Clipped or keyed pixels SHALL still consume their cycle; total draw time SHALL be fixed at N+1 cycles after E0.
REQ-027 done SHALL pulse high for exactly one cycle after edge E(N+1), coincident with busy=0 and return to IDLE.
REQ-028 start SHALL be ignored while busy=1; no queuing.
REQ-029 start held high SHALL retrigger a new draw in the cycle done is high, i.e. the IDLE cycle after FLUSH.
REQ-030 x_org/y_org changes during busy SHALL NOT affect the current draw.

Reset
REQ-031 reset=1 at any edge, including mid-draw, SHALL force IDLE, with busy=0, done=0, plot=0, rom_addr=0, x=0, y=0, and counters=0.
REQ-032 colour SHALL follow rom_q combinationally and is don't-care when plot=0.
REQ-033 reset SHALL take priority over start in the same cycle.

Verification
REQ-034 Bench SHALL use IMG_W=4, IMG_H=3, x_org=10, y_org=5, and start for 1 cycle -> 12 plots on consecutive cycles (10..13,5..7) in raster order; colour equals ROM[k]; done is pulsed once, 13 cycles after start edge.
REQ-035 Bench SHALL test clipping with SCR_W=12, x_org=10 -> plot=1 only for columns 0,1 of each row; done timing is unchanged.
REQ-036 Bench SHALL test KEY_EN=1, KEY_COLOUR=0, with ROM[5]=0 -> pixel 5 has plot=0; all others plot=1.
REQ-037 Bench SHALL drive start pulses during busy -> they are ignored, and exactly one done is produced; start held high -> back-to-back draws separated by one IDLE cycle.
REQ-038 Bench SHALL assert reset at pixel 6 -> next cycle busy=0, plot=0, and rom_addr=0; no done; a subsequent start redraws from pixel 0.
REQ-039 Bench SHALL run the defaults 160x120 at origin 0,0 -> 19200 plots; the last is x=159, y=119 at rom_addr 19199; done follows 1 cycle later.
